// File: rtl/rv32_mem_pkg.sv
// rtl/rv32_mem_pkg.sv - shared encodings for the rv32 fetch/data memory arbiter
package rv32_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/rv32_arb_prio.sv
// rtl/rv32_arb_prio.sv - data-first grant decision with a streak limit protecting fetch
module rv32_arb_prio
    import rv32_mem_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_eval,
    input  logic i_if_req,
    input  logic i_d_req,
    output logic o_grant,
    output logic o_owner
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    logic [SW-1:0] r_streak;
    logic          w_d_wins;

    always_comb begin
        w_d_wins = i_d_req && (!i_if_req || (r_streak < SW'(MAX_D_STREAK)));
    end

    assign o_grant = i_eval && (i_if_req || i_d_req);
    assign o_owner = w_d_wins ? OWN_D : OWN_I;

    // The streak only grows while fetch is actually waiting behind data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak <= '0;
        end else if (o_grant) begin
            if (w_d_wins && i_if_req) begin
                r_streak <= r_streak + 1'b1;
            end else begin
                r_streak <= '0;
            end
        end
    end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// rtl/rv32_mem_arbiter.sv - single-outstanding arbiter sharing one memory port between fetch and data
module rv32_mem_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    arb_state_t    r_state, w_next;
    logic          r_owner, r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [TW-1:0] r_timer;
    logic          r_if_done, r_d_done, r_err;
    logic [DW-1:0] r_if_rdata, r_d_rdata;
    logic          w_grant, w_grant_owner;
    logic          w_finish, w_timeout;
    logic [DW-1:0] w_rdata_in;

    rv32_arb_prio #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_prio (
        .clk      (clk),
        .reset    (reset),
        .i_eval   (r_state == IDLE),
        .i_if_req (if_req),
        .i_d_req  (d_req),
        .o_grant  (w_grant),
        .o_owner  (w_grant_owner)
    );

    always_comb begin
        w_next    = r_state;
        w_finish  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) w_next = REQ;
            end
            REQ: begin
                if (mem_ready) begin
                    if (mem_rvalid) begin
                        w_next   = DONE;
                        w_finish = 1'b1;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                // A response on the final timer cycle still wins over the timeout.
                if (mem_rvalid) begin
                    w_next   = DONE;
                    w_finish = 1'b1;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_next    = DONE;
                    w_finish  = 1'b1;
                    w_timeout = 1'b1;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        w_rdata_in = w_timeout ? '0 : mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= OWN_I;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_timer    <= '0;
            r_if_done  <= 1'b0;
            r_d_done   <= 1'b0;
            r_err      <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_owner <= w_grant_owner;
                r_we    <= (w_grant_owner == OWN_D) && d_we;
                r_addr  <= (w_grant_owner == OWN_D) ? d_addr : if_addr;
                r_wdata <= (w_grant_owner == OWN_D) ? d_wdata : '0;
            end
            if (r_state == REQ && mem_ready) begin
                r_timer <= '0;
            end else if (r_state == WAIT) begin
                r_timer <= r_timer + 1'b1;
            end
            r_if_done <= w_finish && (r_owner == OWN_I);
            r_d_done  <= w_finish && (r_owner == OWN_D);
            r_err     <= w_finish && w_timeout;
            if (w_finish && r_owner == OWN_I) r_if_rdata <= w_rdata_in;
            if (w_finish && r_owner == OWN_D) r_d_rdata  <= w_rdata_in;
        end
    end

    assign mem_req   = (r_state == REQ);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_done   = r_if_done;
    assign d_done    = r_d_done;
    assign err       = r_err;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb/tb_rv32_mem_arbiter.sv - scoreboard bench: directed corner cases plus randomized two-requester traffic
module tb_rv32_mem_arbiter;

    localparam int AW = 32, DW = 32, MAX_D = 4, TMO = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          if_done, d_done, err;
    logic [DW-1:0] if_rdata, d_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready, mem_rvalid;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    rv32_mem_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAX_D), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct { bit own; bit err; logic [31:0] rdata; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0, n_fail = 0, n_pushed = 0, n_done = 0;
    bit   mem_auto = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit own, input bit e, input logic [31:0] d);
        exp_t x;
        x.own = own; x.err = e; x.rdata = d;
        exp_q.push_back(x);
        n_pushed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: who should own the port given the requests seen at grant time.
    bit pi = 0, pd = 0, prev_req = 0, cur_own = 0;
    int streak_m = 0;
    always @(negedge clk) begin
        if (reset) begin
            streak_m = 0;
            prev_req = 0;
        end else begin
            if (mem_req && !prev_req) begin
                check("grant_has_req", {63'b0, pi | pd}, 64'd1);
                if (pd && (!pi || streak_m < MAX_D)) begin
                    cur_own  = 1;
                    streak_m = pi ? streak_m + 1 : 0;
                end else begin
                    cur_own  = 0;
                    streak_m = 0;
                end
            end
            if (mem_req) begin
                check("mem_addr", mem_addr, cur_own ? d_addr : if_addr);
                check("mem_we", mem_we, cur_own ? d_we : 1'b0);
                if (cur_own && d_we) check("mem_wdata", mem_wdata, d_wdata);
            end
            if (if_done || d_done) begin
                n_done++;
                check("single_done", if_done & d_done, 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: if_done=%0b d_done=%0b, expected no completion", if_done, d_done);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_side", d_done, mon_e.own);
                    check("err", err, mon_e.err);
                    check("rdata", d_done ? d_rdata : if_rdata, mon_e.rdata);
                end
            end
            prev_req = mem_req;
        end
        pi = if_req;
        pd = d_req;
    end

    // Randomized memory: variable ready delay, same-cycle / delayed / last-cycle / late responses.
    int          rdy_dly = 0, resp_cnt = 0, mm;
    logic [31:0] resp_val, mv;
    always begin
        @(posedge clk);
        #1;
        if (mem_auto) begin
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom();
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = resp_val;
                end
            end else if (mem_req) begin
                if (rdy_dly > 0) begin
                    rdy_dly--;
                end else begin
                    mem_ready = 1'b1;
                    rdy_dly   = $urandom_range(0, 2);
                    mm        = $urandom_range(0, 19);
                    mv        = $urandom();
                    if (mm < 4) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = mv;
                        push_exp(mem_addr[31], 1'b0, mv);
                    end else if (mm < 18) begin
                        resp_cnt = $urandom_range(1, 4);
                        resp_val = mv;
                        push_exp(mem_addr[31], 1'b0, mv);
                    end else if (mm == 18) begin
                        resp_cnt = TMO;
                        resp_val = mv;
                        push_exp(mem_addr[31], 1'b0, mv);
                    end else begin
                        resp_cnt = TMO + 1;
                        resp_val = mv;
                        push_exp(mem_addr[31], 1'b1, 32'h0);
                    end
                end
            end else begin
                mem_rvalid = ($urandom_range(0, 5) == 0);
            end
        end
    end

    task automatic requester(input bit side, input int n);
        int wait_c, gap;
        bit got;
        for (int t = 0; t < n; t++) begin
            gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            repeat (gap) step();
            if (side) begin
                d_we    = $urandom_range(0, 1);
                d_addr  = 32'h8000_0000 | ($urandom() & 32'h0000_fffc);
                d_wdata = $urandom();
                d_req   = 1'b1;
            end else begin
                if_addr = $urandom() & 32'h0000_fffc;
                if_req  = 1'b1;
            end
            got = 0;
            wait_c = 0;
            while (!got && wait_c < 3000) begin
                step();
                wait_c++;
                got = side ? d_done : if_done;
            end
            if (!got) begin
                n_checks++;
                n_fail++;
                $display("FAIL req_timeout: side=%0d no done within %0d cycles", side, wait_c);
            end
            if (side) d_req = 1'b0;
            else      if_req = 1'b0;
        end
    endtask

    task automatic manual_txn(input bit side, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                              input int rdy_d, input int rv_d, input logic [31:0] rd,
                              output int cyc, output int req_cyc);
        int cnt, k, ph;
        bit got;
        cnt = 0; k = 0; ph = 0; got = 0; cyc = 0; req_cyc = 0;
        if (side) begin
            d_we = we; d_addr = addr; d_wdata = wd; d_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        while (!got && cyc < 200) begin
            step();
            cyc++;
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom();
            got = side ? d_done : if_done;
            if (mem_req) req_cyc++;
            if (!got) begin
                if (ph == 0 && mem_req) begin
                    if (cnt == rdy_d) begin
                        mem_ready = 1'b1;
                        ph = 1;
                        if (rv_d == 0) begin mem_rvalid = 1'b1; mem_rdata = rd; end
                    end else begin
                        cnt++;
                    end
                end else if (ph == 1) begin
                    k++;
                    if (k == rv_d) begin mem_rvalid = 1'b1; mem_rdata = rd; end
                end
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL manual_txn_timeout: side=%0d addr=%0h no done", side, addr);
        end
        if (side) d_req = 1'b0;
        else      if_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, rq, dn;
        reset = 1'b1; if_req = 0; d_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        repeat (3) step();
        check("reset_ctrl", {if_done, d_done, err, mem_req, mem_we}, 0);
        check("reset_addr", mem_addr, 0);
        check("reset_rdata", {if_rdata, d_rdata}, 0);
        reset = 1'b0;
        step();

        push_exp(1'b0, 1'b0, 32'h0050_0093);
        manual_txn(1'b0, 1'b0, 32'h100, 32'h0, 0, 1, 32'h0050_0093, cyc, rq);
        check("fetch_latency", cyc, 3);
        step();

        push_exp(1'b1, 1'b0, 32'h0000_5a5a);
        manual_txn(1'b1, 1'b1, 32'h8000_2000, 32'hDEAD_BEEF, 3, 1, 32'h0000_5a5a, cyc, rq);
        check("store_req_cycles", rq, 4);
        check("store_latency", cyc, 6);
        step();

        push_exp(1'b1, 1'b1, 32'h0);
        manual_txn(1'b1, 1'b0, 32'h8000_0400, 32'h0, 0, 1000, 32'h1111_1111, cyc, rq);
        check("timeout_latency", cyc, TMO + 2);
        mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
        step(); step();
        mem_rvalid = 1'b0;

        push_exp(1'b1, 1'b0, 32'hCAFE_F00D);
        manual_txn(1'b1, 1'b0, 32'h8000_0040, 32'h0, 0, 0, 32'hCAFE_F00D, cyc, rq);
        check("same_cycle_latency", cyc, 2);
        step();

        d_we = 1'b0; d_addr = 32'h8000_3000; d_req = 1'b1;
        cyc = 0;
        while (!mem_req && cyc < 10) begin step(); cyc++; end
        check("reset_test_req", mem_req, 1);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step(); step();
        reset = 1'b1; d_req = 1'b0;
        step();
        check("midreset_ctrl", {if_done, d_done, err, mem_req, mem_we}, 0);
        check("midreset_addr", {mem_addr, mem_wdata}, 0);
        check("midreset_rdata", {if_rdata, d_rdata}, 0);
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h3333_3333;
        dn = 0;
        repeat (3) begin step(); dn += int'(if_done | d_done); end
        mem_rvalid = 1'b0;
        check("no_done_after_reset", dn, 0);

        push_exp(1'b0, 1'b0, 32'h0000_0013);
        manual_txn(1'b0, 1'b0, 32'h104, 32'h0, 0, 1, 32'h0000_0013, cyc, rq);
        check("post_reset_fetch_latency", cyc, 3);
        step();

        mem_auto = 1'b1;
        fork
            requester(1'b0, 40);
            requester(1'b1, 40);
        join
        repeat (100) step();
        check("scoreboard_empty", exp_q.size(), 0);
        check("done_count", n_done, n_pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
